// File: rtl/dotbox_pkg.sv
// Shared types and sizing for the dotbox feeder: element geometry, FSM state
// encoding, the packed vector type and the result record.
package dotbox_pkg;

  localparam int N_ELEM = 8;
  localparam int W      = 16;
  localparam int IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } feeder_state_t;

  typedef logic signed [N_ELEM-1:0][W-1:0] vec_t;

  typedef struct packed {
    logic [31:0] dat32;
    logic [15:0] dat16;
    logic        timeout;
  } result_t;

endpackage

// File: rtl/dotbox_vec_regs.sv
// Indexed X/Y element register file; element idx is overwritten on we and the
// full vectors are presented packed to the dotbox inputs.
module dotbox_vec_regs
  import dotbox_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  output vec_t             vec_x,
  output vec_t             vec_y
);

  // NOTE: this storage is reset on purpose so a reset discards any partially
  // loaded vector; that keeps it as plain flops rather than an inferable RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_x <= '0;
      vec_y <= '0;
    end else if (we) begin
      vec_x[idx] <= x;
      vec_y[idx] <= y;
    end
  end

endmodule

// File: rtl/dotbox_feeder.sv
// Streams N_ELEM X/Y pairs into the dotbox input vectors, pulses start, waits
// (with timeout) for the completion strobe and returns the result on a valid/ready port.
module dotbox_feeder
  import dotbox_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [W-1:0]        s_x,
  input  logic [W-1:0]        s_y,
  output logic [N_ELEM*W-1:0] db_x,
  output logic [N_ELEM*W-1:0] db_y,
  output logic                db_start,
  input  logic [31:0]         db_dat,
  input  logic [15:0]         db_dat16,
  input  logic                db_xfc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [31:0]         m_dat,
  output logic [15:0]         m_dat16,
  output logic                m_timeout,
  output logic                busy
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  feeder_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo_cnt;
  result_t          res;
  vec_t             vec_x;
  vec_t             vec_y;
  logic             wr_en;

  assign wr_en = (state == ST_LOAD) && s_valid && s_ready;

  dotbox_vec_regs u_vec_regs (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .idx   (idx),
    .x     (s_x),
    .y     (s_y),
    .vec_x (vec_x),
    .vec_y (vec_y)
  );

  assign db_x      = vec_x;
  assign db_y      = vec_y;
  assign m_dat     = res.dat32;
  assign m_dat16   = res.dat16;
  assign m_timeout = res.timeout;

  // NOTE: non-blocking assignments throughout, so every branch below sees the
  // pre-edge value of state/idx/tmo_cnt regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOAD;
      idx      <= '0;
      tmo_cnt  <= '0;
      db_start <= 1'b0;
      m_valid  <= 1'b0;
      res      <= '0;
      s_ready  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      db_start <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          if (s_valid && s_ready) begin
            if (idx == IDX_LAST) begin
              idx      <= '0;
              state    <= ST_START;
              db_start <= 1'b1;
              s_ready  <= 1'b0;
              busy     <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_START: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          // A completion arriving on the timeout cycle still delivers real data.
          if (db_xfc) begin
            res     <= '{dat32: db_dat, dat16: db_dat16, timeout: 1'b0};
            m_valid <= 1'b1;
            state   <= ST_HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            res     <= '{dat32: 32'd0, dat16: 16'd0, timeout: 1'b1};
            m_valid <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dotbox_feeder.sv
// Directed bench for dotbox_feeder with a small dotbox responder model that
// answers a fixed number of cycles after db_start.
module tb_dotbox_feeder;

  logic         clk;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [15:0]  s_x;
  logic [15:0]  s_y;
  logic [127:0] db_x;
  logic [127:0] db_y;
  logic         db_start;
  logic [31:0]  db_dat;
  logic [15:0]  db_dat16;
  logic         db_xfc;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_dat;
  logic [15:0]  m_dat16;
  logic         m_timeout;
  logic         busy;

  int vectors    = 0;
  int miscompares = 0;

  int cyc        = 0;
  int start_cnt  = 0;
  int start_cyc  = 0;
  int op_starts  = 0;
  bit mvalid_seen = 0;

  // responder model state
  bit model_en   = 0;
  int model_lat  = 3;
  int model_cnt  = 0;
  bit force_xfc  = 0;

  dotbox_feeder #(.TIMEOUT_CYCLES(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_x       (s_x),
    .s_y       (s_y),
    .db_x      (db_x),
    .db_y      (db_y),
    .db_start  (db_start),
    .db_dat    (db_dat),
    .db_dat16  (db_dat16),
    .db_xfc    (db_xfc),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_dat     (m_dat),
    .m_dat16   (m_dat16),
    .m_timeout (m_timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, then update the responder model and monitors.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (db_start) start_cnt++;
    if (m_valid) mvalid_seen = 1;
    db_xfc = force_xfc;
    if (model_cnt != 0) begin
      model_cnt--;
      if (model_cnt == 0) db_xfc = 1'b1;
    end
    if (db_start && model_en) model_cnt = model_lat;
  endtask

  task automatic load_vec(input string tag, input logic [127:0] xv, input logic [127:0] yv,
                          input bit bubbles);
    op_starts = start_cnt;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_x = xv[i*16 +: 16];
      s_y = yv[i*16 +: 16];
      tick();
      if (bubbles && i < 7) begin
        s_valid = 1'b0;
        s_x = 16'hBAD0;
        s_y = 16'hBAD1;
        tick();
      end
    end
    s_valid = 1'b0;
    check({tag, "_start_hi"}, db_start, 1'b1);
    start_cyc = cyc;
    check({tag, "_db_x"}, db_x, xv);
    check({tag, "_db_y"}, db_y, yv);
    tick();
    check({tag, "_start_lo"}, db_start, 1'b0);
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_dat,
                             input logic [15:0] exp_dat16, input bit exp_tmo);
    for (int n = 0; n < 200 && !m_valid; n++) tick();
    check({tag, "_m_valid"}, m_valid, 1'b1);
    check({tag, "_latency"}, 128'(cyc - start_cyc), 128'(exp_lat));
    check({tag, "_one_start"}, 128'(start_cnt - op_starts), 128'd1);
    check({tag, "_m_dat"}, m_dat, exp_dat);
    check({tag, "_m_dat16"}, m_dat16, exp_dat16);
    check({tag, "_m_timeout"}, m_timeout, exp_tmo);
    check({tag, "_s_ready_lo"}, s_ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic handshake(input string tag);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({tag, "_s_ready_hi"}, s_ready, 1'b1);
    check({tag, "_m_valid_lo"}, m_valid, 1'b0);
    check({tag, "_busy_lo"}, busy, 1'b0);
  endtask

  initial begin
    reset    = 1'b1;
    s_valid  = 1'b0;
    s_x      = '0;
    s_y      = '0;
    db_dat   = '0;
    db_dat16 = '0;
    db_xfc   = 1'b0;
    m_ready  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_db_start", db_start, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_timeout", m_timeout, 1'b0);
    check("rst_m_dat", {m_dat, m_dat16}, 48'h0);
    check("rst_db_x", db_x, 128'h0);

    // basic load: X=1..8, Y=1 -> 36
    model_en = 1; model_lat = 3;
    db_dat = 32'h0000_0024; db_dat16 = 16'h0024;
    load_vec("basic", 128'h0008_0007_0006_0005_0004_0003_0002_0001,
             {8{16'h0001}}, 1'b0);
    wait_result("basic", 4, 32'h0000_0024, 16'h0024, 1'b0);
    handshake("basic");

    // signed values with result backpressure
    db_dat = 32'hFFFF_FFF0; db_dat16 = 16'hFFF0;
    load_vec("signed", {8{16'hFFFF}}, {8{16'h0002}}, 1'b0);
    wait_result("signed", 4, 32'hFFFF_FFF0, 16'hFFF0, 1'b0);
    db_dat = 32'h1111_1111; db_dat16 = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_m_dat", m_dat, 32'hFFFF_FFF0);
      check("bp_m_valid", m_valid, 1'b1);
      check("bp_s_ready", s_ready, 1'b0);
    end
    handshake("signed");

    // timeout, then a spurious completion while holding the result
    model_en = 0;
    load_vec("tmo", 128'h0001_0002_0003_0004_0005_0006_0007_0008, {8{16'h0003}}, 1'b0);
    wait_result("tmo", 65, 32'h0, 16'h0, 1'b1);
    db_dat = 32'hDEAD_BEEF; db_dat16 = 16'hBEEF;
    force_xfc = 1'b1;
    tick();
    force_xfc = 1'b0;
    tick();
    tick();
    check("spur_m_dat", m_dat, 32'h0);
    check("spur_m_timeout", m_timeout, 1'b1);
    check("spur_m_valid", m_valid, 1'b1);
    handshake("tmo");

    // reset after five accepts discards the partial vector
    op_starts = start_cnt;
    mvalid_seen = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_x = 16'h0A00 + 16'(i); s_y = 16'h0B00 + 16'(i);
      tick();
    end
    s_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rl_db_x", db_x, 128'h0);
    check("rl_s_ready", s_ready, 1'b1);

    // reset while waiting for completion
    load_vec("rw", {8{16'h0005}}, {8{16'h0006}}, 1'b0);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    op_starts = start_cnt;
    repeat (80) tick();
    check("rw_no_start", 128'(start_cnt - op_starts), 128'd0);
    check("rw_no_m_valid", mvalid_seen, 1'b0);
    check("rw_s_ready", s_ready, 1'b1);

    // recovery: full load after resets gives a correct result
    model_en = 1; model_lat = 3;
    db_dat = 32'h0000_0048; db_dat16 = 16'h0048;
    load_vec("recov", 128'h0008_0007_0006_0005_0004_0003_0002_0001, {8{16'h0002}}, 1'b0);
    wait_result("recov", 4, 32'h0000_0048, 16'h0048, 1'b0);
    handshake("recov");

    // bubbles on s_valid, completion landing on the timeout cycle
    model_lat = 64;
    db_dat = 32'h1234_5678; db_dat16 = 16'h5678;
    load_vec("bubble", 128'h1007_1006_1005_1004_1003_1002_1001_1000,
             128'h2007_2006_2005_2004_2003_2002_2001_2000, 1'b1);
    wait_result("bubble", 65, 32'h1234_5678, 16'h5678, 1'b0);
    handshake("bubble");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dotbox_feeder.md
Name: dotbox_feeder

Overview:
- Initiator-side front end for the dotbox responder. Accepts X/Y element pairs serially on a valid/ready stream and assembles them into the 8x16 IN_X/IN_Y vectors.
- Issues a one-cycle start pulse, waits for the dotbox transfer-complete strobe, and returns the 32-bit and 16-bit results on a valid/ready result port.
- Sits between the host/DMA streaming fabric and the dotbox instance, replacing the bench-driven stimulus path in the integrated design.

Parameters:
- N_ELEM, 8, number of element pairs per dot product.
- W, 16, element width in bits (signed).
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before reporting a timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input element pair valid.
- s_ready  out  1  feeder can accept an element pair.
- s_x  in  W  signed X element.
- s_y  in  W  signed Y element.
- db_x  out  N_ELEM*W  packed X vector to dotbox IN_X; element i at bits [i*W +: W].
- db_y  out  N_ELEM*W  packed Y vector to dotbox IN_Y; same packing as db_x.
- db_start  out  1  one-cycle start pulse to dotbox IN_START.
- db_dat  in  32  dotbox OUT_DAT.
- db_dat16  in  16  dotbox OUT_DAT16.
- db_xfc  in  1  dotbox OUT_XFC, single-cycle completion strobe.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_dat  out  32  captured 32-bit result.
- m_dat16  out  16  captured 16-bit result.
- m_timeout  out  1  result is a timeout record, qualified by m_valid.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset values:
  - state = LOAD, idx = 0, tmo_cnt = 0.
  - db_x, db_y, m_dat, m_dat16 = 0.
  - db_start, m_valid, m_timeout = 0.
  - s_ready = 1 in the first cycle after reset deasserts.
- States: LOAD, START, WAIT, HOLD.
- LOAD:
  - s_ready = 1.
  - On s_valid && s_ready, write s_x/s_y into element idx and increment idx.
  - If the accepted element is idx == N_ELEM-1, go to START and reset idx to 0.
- START:
  - db_start = 1 for exactly this one cycle.
  - db_start is registered, so it is high in the cycle after the last element is accepted.
  - Go to WAIT; clear tmo_cnt.
- WAIT:
  - s_ready = 0; tmo_cnt increments each cycle.
  - If db_xfc: capture db_dat/db_dat16 into m_dat/m_dat16, set m_timeout = 0, go to HOLD.
  - Else if tmo_cnt == TIMEOUT_CYCLES-1: set m_dat = 0, m_dat16 = 0, m_timeout = 1, go to HOLD.
  - db_xfc and timeout in the same cycle: db_xfc wins and the real result is captured.
- HOLD:
  - m_valid = 1; m_dat, m_dat16 and m_timeout are held stable until the handshake.
  - On m_ready, go to LOAD.
  - m_valid is high starting the cycle after db_xfc is sampled.
- db_xfc outside WAIT is ignored: no capture, no state change.
- db_x and db_y hold the last loaded vectors until overwritten element by element in the next LOAD. They are not cleared between operations.
- s_ready is a registered state decode; it depends only on the FSM state and never combinationally on m_ready or db_xfc.
- There is no bypass. The next load starts only after the result handshake, so at most one operation is outstanding.
- Reset mid-operation: all registers return to their reset values, no db_start is issued, and a partially loaded vector is discarded.
- Widths: the counter width is $clog2(TIMEOUT_CYCLES). idx width is $clog2(N_ELEM). No arithmetic is performed on the data; it passes through unaltered.

Decomposition:
- Package dotbox_pkg holds:
  - N_ELEM and W localparams;
  - the typedef enum for the feeder state (LOAD, START, WAIT, HOLD);
  - typedef vec_t = logic signed [N_ELEM-1:0][W-1:0];
  - typedef struct result_t {dat32, dat16, timeout}.
- One sub-module is natural: dotbox_vec_regs, the indexed X/Y element register file.
  - Inputs: write enable, idx, x, y.
  - Outputs: packed vectors.
- The FSM and timeout counter stay in dotbox_feeder.

Test Plan:
- Basic load: stream X=1..8, Y=1 (all), bench dotbox model returns db_dat=0x00000024, db_dat16=0x0024 three cycles after db_start -> exactly one db_start pulse one cycle after the 8th accept; m_valid with m_dat=0x00000024, m_dat16=0x0024, m_timeout=0.
- Signed values: X=0xFFFF (all), Y=0x0002 (all), model returns 0xFFFFFFF0/0xFFF0 -> m_dat=0xFFFFFFF0, m_dat16=0xFFF0; db_x equals 0xFFFF replicated 8 times.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid -> m_dat stable, s_ready=0 throughout; s_ready=1 the cycle after the handshake.
- Timeout: model never asserts db_xfc -> m_valid exactly TIMEOUT_CYCLES cycles after db_start deasserts, m_timeout=1, m_dat=0; a spurious db_xfc during HOLD is ignored.
- Reset mid-load and mid-WAIT: assert reset after 5 accepts, and again in WAIT -> no db_start and no m_valid; the next full 8-pair load produces a correct result.
- Bubbles: s_valid toggling 1/0 every cycle across 8 elements -> elements land at indices 0..7 in order; db_xfc coinciding with the timeout cycle captures the real result with m_timeout=0.
